multicycle_adder: RTL and testbench
===================================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, NCH = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = add, 1 = subtract; captured with start.
REQ-007 a  input  WIDTH  operand A (two's complement or unsigned); captured with start.
REQ-008 b  input  WIDTH  operand B; captured with start.
REQ-009 cin  input  1  carry-in (add) / borrow-in (subtract); captured with start.
REQ-010 s  output  WIDTH  registered result.
REQ-011 cout  output  1  registered carry-out of MSB chunk.
REQ-012 ovf  output  1  registered signed-overflow flag.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle pulse marking new valid s/cout/ovf.

Function
REQ-015 FSM SHALL have two states: IDLE and RUN.
REQ-016 IDLE -> RUN on edge where start=1; a, b, cin, sub latched into internal registers on that edge; chunk index cleared to 0.
REQ-017 In IDLE with start=0, state and all outputs SHALL hold.
REQ-018 Add: result = a + b + cin; subtract: result = a + ~b + ~cin (i.e. a - b - cin).
REQ-019 In RUN, each edge SHALL add one CHUNK-bit slice (LSB slice first) of latched A and effective B plus the registered running carry; slice sum stored, carry registered for next slice.
REQ-020 Running carry SHALL initialise to cin (add) or ~cin (subtract) at capture.
REQ-021 RUN -> IDLE on the edge processing slice NCH-1; on that same edge s, cout, ovf SHALL be loaded and done set to 1.
REQ-022 Latency: start sampled at edge k -> done=1 and results valid in the cycle following edge k+NCH; busy=1 in cycles following edges k .. k+NCH-1.
REQ-023 cout SHALL be raw carry out of bit WIDTH-1 (subtract: 1 = no borrow).
REQ-024 ovf SHALL be carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-025 s, cout, ovf SHALL hold their last values while busy and in IDLE until the next completion; partial sums never appear on s.
REQ-026 done SHALL be high exactly one cycle per completed operation.
REQ-027 start while busy=1 SHALL be ignored, with no queuing; input changes during RUN SHALL not affect the result.
REQ-028 start asserted in the cycle done=1 SHALL be accepted (back-to-back throughput of one result per NCH+1 cycles).
REQ-029 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.
REQ-030 CHUNK = WIDTH (NCH = 1) SHALL be legal: latency 1, behaviour otherwise identical.

Reset
REQ-031 rst=1 on an edge SHALL force IDLE, s=0, cout=0, ovf=0, busy=0, done=0, clear internal carry, operand and index registers.
REQ-032 rst SHALL take priority over start and over an operation in progress; an aborted operation SHALL produce no done pulse.
REQ-033 First edge with rst=0 SHALL see IDLE and may accept start.

Verification (WIDTH=16, CHUNK=4, NCH=4)
REQ-034 a=0x00FF, b=0x0001, cin=0, sub=0, start one cycle -> busy 4 cycles, then done=1 with s=0x0100, cout=0, ovf=0.
REQ-035 a=0xFFFF, b=0x0001, cin=0, add -> s=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0000, cin=1, add -> s=0x8000, cout=0, ovf=1.
REQ-036 a=0x0005, b=0x0007, cin=0, sub=1 -> s=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
REQ-037 start pulsed again 2 cycles after accepted start, with different a/b -> ignored; single done with first operation's result.
REQ-038 rst=1 asserted 2 cycles into RUN -> next cycle busy=0, done=0, s=0, cout=0, ovf=0; no done pulse follows.
REQ-039 start held high continuously, a/b incrementing by 1 each result -> done every 5 cycles, each s = a+b of the operands captured at the corresponding accept edge.

Source files
------------

// File: rtl/multicycle_adder.sv
// Chunk-serial adder/subtractor: one CHUNK-bit slice per clock, LSB slice first.
// s/cout/ovf update only on completion, and done pulses on the same edge.
module multicycle_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CHUNK:0]     slice_sum;
    logic               msb_carry_in;

    // Operand registers shift right each slice, so the active slice always sits at bit 0.
    assign slice_sum = (CHUNK+1)'(a_q[CHUNK-1:0])
                     + (CHUNK+1)'(b_q[CHUNK-1:0])
                     + (CHUNK+1)'(carry_q);

    // Carry into the slice MSB recovered from the sum bit: c = a ^ b ^ sum.
    assign msb_carry_in = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_sum[CHUNK-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // Each slice enters at the top of the accumulator and walks down.
                acc_d   = (acc_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_sum[CHUNK];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NCH - 1)) begin
                    state_d = IDLE;
                    s_d     = acc_d;
                    cout_d  = slice_sum[CHUNK];
                    ovf_d   = msb_carry_in ^ slice_sum[CHUNK];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder (WIDTH=16, CHUNK=4): directed table,
// random operations against an arithmetic model, and multi-cycle corner sequences.
module tb_multicycle_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CHUNK = 4;
    localparam int unsigned NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    int n_chk  = 0;
    int n_fail = 0;

    multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic; overflow from operand/result sign rule.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                               input logic mcin, input logic msub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        logic             c;
        logic             v;
        bb   = msub ? ~mb : mb;
        c    = msub ? ~mcin : mcin;
        full = {1'b0, ma} + {1'b0, bb} + (WIDTH+1)'(c);
        v    = (ma[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        return {full[WIDTH], v, full[WIDTH-1:0]};
    endfunction

    // Issue one operation and wait for done; reports latency and busy cycles.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic icin, input logic isub,
                          output logic [WIDTH-1:0] rs, output logic rc, output logic ro,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            lat++;
            @(negedge clk);
        end
        rs = s; rc = cout; ro = ovf;
    endtask

    vec_t             vecs[6];
    logic [WIDTH-1:0] rs;
    logic             rc, ro;
    int               lat, bcnt;
    logic [WIDTH+1:0] exp;

    initial begin
        vecs[0] = '{"carry_ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{"wrap_add",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"pos_ovf",      16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"sub_neg",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_ovf",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{"sub_borrow",   16'h1234, 16'h0034, 1'b1, 1'b1, 16'h11FF, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_s",    32'(s),    32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat, bcnt);
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(NCH));
            chk({vecs[i].name, "_busy"}, 32'(bcnt), 32'(NCH));
            chk({vecs[i].name, "_s"}, 32'(rs), 32'(vecs[i].s));
            chk({vecs[i].name, "_cout"}, 32'(rc), 32'(vecs[i].cout));
            chk({vecs[i].name, "_ovf"}, 32'(ro), 32'(vecs[i].ovf));
            @(negedge clk);
            chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
        end

        // Idle hold: inputs wiggle with start low, outputs must not move
        begin
            logic [WIDTH-1:0] held;
            held = s;
            repeat (4) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom); cin = 1'($urandom);
                @(negedge clk);
            end
            chk("idle_hold_s", 32'(s), 32'(held));
            chk("idle_hold_busy", 32'(busy), 32'd0);
            chk("idle_hold_done", 32'(done), 32'd0);
        end

        // Random operations against the model
        for (int i = 0; i < 30; i++) begin
            logic [WIDTH-1:0] ra, rb;
            logic             rci, rsu;
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            rci = 1'($urandom); rsu = 1'($urandom);
            if (i < 4) begin
                ra = (i[0]) ? 16'h8000 : 16'h7FFF;
                rb = (i[1]) ? 16'hFFFF : 16'h8000;
            end
            exp = model(ra, rb, rci, rsu);
            run_op(ra, rb, rci, rsu, rs, rc, ro, lat, bcnt);
            chk($sformatf("rand%0d_s", i), 32'(rs), 32'(exp[WIDTH-1:0]));
            chk($sformatf("rand%0d_cout", i), 32'(rc), 32'(exp[WIDTH+1]));
            chk($sformatf("rand%0d_ovf", i), 32'(ro), 32'(exp[WIDTH]));
            chk($sformatf("rand%0d_lat", i), 32'(lat), 32'(NCH));
        end

        // Start during RUN is ignored and input changes do not disturb the result
        begin
            int ndone;
            ndone = 0;
            @(negedge clk);
            a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            a = 16'h0F0F; b = 16'h0101; cin = 1'b1; sub = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0; a = 16'hAAAA;
            for (int c = 0; c < 12; c++) begin
                if (done) begin
                    ndone++;
                    chk("ignored_start_s", 32'(s), 32'h3333);
                    chk("ignored_start_cout", 32'(cout), 32'd0);
                end
                @(negedge clk);
            end
            chk("ignored_start_dones", 32'(ndone), 32'd1);
        end

        // Reset mid-operation aborts with no done pulse
        begin
            int ndone;
            ndone = 0;
            chk("pre_abort_s_nonzero", 32'(s != '0), 32'd1);
            @(negedge clk);
            a = 16'h4321; b = 16'h1234; cin = 1'b0; sub = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1; start = 1'b1;
            @(negedge clk);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_s",    32'(s),    32'd0);
            chk("abort_cout", 32'(cout), 32'd0);
            chk("abort_ovf",  32'(ovf),  32'd0);
            rst = 1'b0; start = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (done) ndone++;
                @(negedge clk);
            end
            chk("abort_no_done", 32'(ndone), 32'd0);
        end

        // Start held high: back-to-back operations every NCH+1 cycles
        begin
            logic [WIDTH-1:0] q[$];
            int ndone, cyc, last_cyc;
            ndone = 0; cyc = 0; last_cyc = -1;
            a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0; start = 1'b1;
            q.push_back(16'h0300);
            while (ndone < 6 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (done) begin
                    ndone++;
                    if (q.size() > 0) chk("b2b_s", 32'(s), 32'(q.pop_front()));
                    else chk("b2b_queue_empty", 32'd1, 32'd0);
                    if (last_cyc >= 0) chk("b2b_interval", 32'(cyc - last_cyc), 32'(NCH + 1));
                    last_cyc = cyc;
                    a = a + 16'd1; b = b + 16'd1;
                    if (ndone < 6) q.push_back(a + b);
                    else start = 1'b0;
                end
            end
            chk("b2b_count", 32'(ndone), 32'd6);
            start = 1'b0;
            repeat (NCH + 2) @(negedge clk);
            chk("b2b_final_idle", 32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
